// File: rtl/div_unit.sv
// div_unit: iterative restoring divider for DIV/DIVU (quotient -> LO, remainder -> HI).
// One restoring step per cycle on operand magnitudes, with signs fixed up at the end.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   start        request pulse, sampled only while idle
//   is_signed    1 = signed divide, 0 = unsigned; sampled with start
//   dividend     numerator, sampled with start
//   divisor      denominator, sampled with start
//   busy         high while an operation is in flight
//   done         one-cycle pulse when quotient/remainder are updated
//   div_by_zero  status of the last completed operation
//   quotient     result for LO
//   remainder    result for HI
module div_unit #(
    parameter int WORD_LENGTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   is_signed,
    input  logic [WORD_LENGTH-1:0] dividend,
    input  logic [WORD_LENGTH-1:0] divisor,
    output logic                   busy,
    output logic                   done,
    output logic                   div_by_zero,
    output logic [WORD_LENGTH-1:0] quotient,
    output logic [WORD_LENGTH-1:0] remainder
);
    localparam int W  = WORD_LENGTH;
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    state_t        state;
    logic [W:0]    pr;       // partial remainder
    logic [W-1:0]  dq;       // dividend magnitude shifting out, quotient bits shifting in
    logic [W-1:0]  dm;       // divisor magnitude
    logic [CW-1:0] count;
    logic          neg_q, neg_r, dz;

    // Magnitudes are plain unsigned W-bit values, so 2^(W-1) survives negation.
    logic [W-1:0] mag_a, mag_b;
    assign mag_a = (is_signed && dividend[W-1]) ? -dividend : dividend;
    assign mag_b = (is_signed && divisor[W-1])  ? -divisor  : divisor;

    // One restoring step. pr < dm < 2^W, so the shifted value fits in W+1 bits
    // and bit W+1 of the difference is purely the borrow.
    logic [W+1:0] shifted, diff;
    logic         step_ok;
    assign shifted = {pr, dq[W-1]};
    assign diff    = shifted - {2'b00, dm};
    assign step_ok = ~diff[W+1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            pr          <= '0;
            dq          <= '0;
            dm          <= '0;
            count       <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            dz          <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        // On divide-by-zero the raw dividend is parked in dq so
                        // it can be returned unmodified as the remainder.
                        dq    <= (divisor == '0) ? dividend : mag_a;
                        dm    <= mag_b;
                        pr    <= '0;
                        count <= '0;
                        neg_q <= is_signed & (dividend[W-1] ^ divisor[W-1]);
                        neg_r <= is_signed & dividend[W-1];
                        dz    <= (divisor == '0);
                        busy  <= 1'b1;
                        state <= (divisor == '0) ? FINISH : RUN;
                    end
                end
                RUN: begin
                    pr    <= step_ok ? diff[W:0] : shifted[W:0];
                    dq    <= {dq[W-2:0], step_ok};
                    count <= count + 1'b1;
                    if (count == CW'(W - 1))
                        state <= FINISH;
                end
                FINISH: begin
                    if (dz) begin
                        quotient  <= '1;
                        remainder <= dq;
                    end else begin
                        quotient  <= neg_q ? -dq : dq;
                        remainder <= neg_r ? -pr[W-1:0] : pr[W-1:0];
                    end
                    div_by_zero <= dz;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
